// File: rtl/router_cfg_sequencer_pkg.sv
// Shared types and field layout for the router configuration sequencer.
// A context word is {regbypass, sel[out6] .. sel[out0]}, one select field per output.
package router_cfg_sequencer_pkg;

    localparam int unsigned CFG_NUM_PORTS  = 7;
    localparam int unsigned CFG_NUM_REG    = 4;
    localparam int unsigned CFG_SEL_W      = CFG_NUM_PORTS;
    localparam int unsigned CFG_XBAR_LSB   = 0;
    localparam int unsigned CFG_XBAR_W     = CFG_NUM_PORTS * CFG_SEL_W;
    localparam int unsigned CFG_REGBYP_LSB = CFG_XBAR_LSB + CFG_XBAR_W;
    localparam int unsigned CFG_WORD_W     = CFG_REGBYP_LSB + CFG_NUM_REG;

    typedef enum logic [1:0] {
        CFG_SEQ_IDLE,
        CFG_SEQ_RUN,
        CFG_SEQ_DONE
    } cfg_seq_state_e;

endpackage

// File: rtl/router_cfg_sequencer_ctx_mem.sv
// Context memory: one write port and one registered read port.
// Not reset; contents are undefined until written by the host.
module cfg_ctx_mem #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 53,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk_g_0,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_g_0) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/router_cfg_sequencer.sv
// Replays crossbar-select/regbypass context words modulo II for a programmed
// number of iterations, with multi-hot select suppression and sticky error.
module router_cfg_sequencer
    import router_cfg_sequencer_pkg::*;
#(
    parameter int unsigned NUM_PORTS = CFG_NUM_PORTS,
    parameter int unsigned NUM_REG   = CFG_NUM_REG,
    parameter int unsigned CFG_DEPTH = 16,
    parameter int unsigned ITER_W    = 16,
    localparam int unsigned CTX_W    = $clog2(CFG_DEPTH),
    localparam int unsigned XBAR_W   = NUM_PORTS * NUM_PORTS,
    localparam int unsigned CFG_W    = XBAR_W + NUM_REG
) (
    input  logic               clk_g_0,
    input  logic               reset,
    input  logic               i__cfg_we,
    input  logic [CTX_W-1:0]   i__cfg_addr,
    input  logic [CFG_W-1:0]   i__cfg_data,
    input  logic [CTX_W:0]     i__ii,
    input  logic [ITER_W-1:0]  i__iter_count,
    input  logic               i__start,
    input  logic               i__stop,
    output logic [XBAR_W-1:0]  o__xbar_sel,
    output logic [NUM_REG-1:0] o__regbypass,
    output logic               o__start_exec_shifted,
    output logic [CTX_W-1:0]   o__ctx,
    output logic               o__busy,
    output logic               o__done,
    output logic               o__err
);

    cfg_seq_state_e    state_q, state_d;
    logic [CTX_W-1:0]  ctx_q, ctx_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic [ITER_W-1:0] iter_max_q, iter_max_d;
    logic [CTX_W:0]    ii_q, ii_d;
    logic              err_q, valid_q;
    logic              err_set, mem_we, last_ctx, last_iter;
    logic [CFG_W-1:0]  rd_data;
    logic [XBAR_W-1:0] xbar_f;
    logic [NUM_PORTS-1:0] field;
    logic              multi_hot;

    cfg_ctx_mem #(
        .DEPTH (CFG_DEPTH),
        .WIDTH (CFG_W)
    ) u_ctx_mem (
        .clk_g_0 (clk_g_0),
        .we      (mem_we),
        .waddr   (i__cfg_addr),
        .wdata   (i__cfg_data),
        .re      (state_q == CFG_SEQ_RUN),
        .raddr   (ctx_q),
        .rdata   (rd_data)
    );

    assign last_ctx  = ({1'b0, ctx_q} == (ii_q - (CTX_W+1)'(1)));
    assign last_iter = (iter_max_q != '0) && (iter_q == (iter_max_q - ITER_W'(1)));

    always_comb begin
        state_d    = state_q;
        ctx_d      = ctx_q;
        iter_d     = iter_q;
        ii_d       = ii_q;
        iter_max_d = iter_max_q;
        err_set    = 1'b0;
        mem_we     = 1'b0;
        unique case (state_q)
            CFG_SEQ_IDLE: begin
                if (i__cfg_we) begin
                    if ({1'b0, i__cfg_addr} < (CTX_W+1)'(CFG_DEPTH)) mem_we = 1'b1;
                    else err_set = 1'b1;
                end
                if (i__start) begin
                    if (i__ii != '0) begin
                        state_d    = CFG_SEQ_RUN;
                        ii_d       = (i__ii > (CTX_W+1)'(CFG_DEPTH)) ? (CTX_W+1)'(CFG_DEPTH) : i__ii;
                        iter_max_d = i__iter_count;
                        ctx_d      = '0;
                        iter_d     = '0;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            CFG_SEQ_RUN: begin
                if (i__cfg_we) err_set = 1'b1;
                if (last_ctx) begin
                    ctx_d  = '0;
                    iter_d = iter_q + ITER_W'(1);
                end else begin
                    ctx_d = ctx_q + CTX_W'(1);
                end
                if (i__stop || last_ctx && last_iter) state_d = CFG_SEQ_DONE;
            end
            CFG_SEQ_DONE: begin
                if (i__cfg_we) err_set = 1'b1;
                state_d = CFG_SEQ_IDLE;
            end
            default: state_d = CFG_SEQ_IDLE;
        endcase
    end

    // Multi-hot select fields are forced to zero (output idle) on the way out.
    always_comb begin
        xbar_f    = '0;
        field     = '0;
        multi_hot = 1'b0;
        for (int unsigned j = 0; j < NUM_PORTS; j++) begin
            field = rd_data[j*NUM_PORTS +: NUM_PORTS];
            if ((field & (field - NUM_PORTS'(1))) != '0) multi_hot = 1'b1;
            else xbar_f[j*NUM_PORTS +: NUM_PORTS] = field;
        end
    end

    always_ff @(posedge clk_g_0) begin
        if (reset) begin
            state_q    <= CFG_SEQ_IDLE;
            ctx_q      <= '0;
            iter_q     <= '0;
            iter_max_q <= '0;
            ii_q       <= '0;
            err_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctx_q      <= ctx_d;
            iter_q     <= iter_d;
            iter_max_q <= iter_max_d;
            ii_q       <= ii_d;
            err_q      <= err_q | err_set | (valid_q & multi_hot);
            valid_q    <= (state_q == CFG_SEQ_RUN);
        end
    end

    assign o__xbar_sel           = valid_q ? xbar_f : '0;
    assign o__regbypass          = valid_q ? rd_data[XBAR_W +: NUM_REG] : '0;
    assign o__start_exec_shifted = valid_q;
    assign o__ctx                = ctx_q;
    assign o__busy               = (state_q != CFG_SEQ_IDLE);
    assign o__done               = (state_q == CFG_SEQ_DONE);
    assign o__err                = err_q;

endmodule

// File: tb/tb_router_cfg_sequencer.sv
// Scoreboard bench for router_cfg_sequencer: expected words queued at start,
// popped whenever the DUT flags a valid output word.
module tb_router_cfg_sequencer;

    bit          clk_g_0 = 1'b0;
    logic        reset;
    logic        i__cfg_we;
    logic [3:0]  i__cfg_addr;
    logic [52:0] i__cfg_data;
    logic [4:0]  i__ii;
    logic [15:0] i__iter_count;
    logic        i__start;
    logic        i__stop;
    logic [48:0] o__xbar_sel;
    logic [3:0]  o__regbypass;
    logic        o__start_exec_shifted;
    logic [3:0]  o__ctx;
    logic        o__busy;
    logic        o__done;
    logic        o__err;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [52:0] tb_mem [16];
    logic [52:0] sb [$];
    bit          mon_en = 1'b0;

    always #5 clk_g_0 = ~clk_g_0;

    router_cfg_sequencer #(
        .NUM_PORTS (7),
        .NUM_REG   (4),
        .CFG_DEPTH (16),
        .ITER_W    (16)
    ) dut (
        .clk_g_0               (clk_g_0),
        .reset                 (reset),
        .i__cfg_we             (i__cfg_we),
        .i__cfg_addr           (i__cfg_addr),
        .i__cfg_data           (i__cfg_data),
        .i__ii                 (i__ii),
        .i__iter_count         (i__iter_count),
        .i__start              (i__start),
        .i__stop               (i__stop),
        .o__xbar_sel           (o__xbar_sel),
        .o__regbypass          (o__regbypass),
        .o__start_exec_shifted (o__start_exec_shifted),
        .o__ctx                (o__ctx),
        .o__busy               (o__busy),
        .o__done               (o__done),
        .o__err                (o__err)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [52:0] model_out(input logic [52:0] w);
        logic [52:0] r;
        r = w;
        for (int j = 0; j < 7; j++)
            if ($countones(w[j*7 +: 7]) > 1) r[j*7 +: 7] = 7'd0;
        return r;
    endfunction

    always @(negedge clk_g_0) begin
        if (mon_en) begin
            if (o__start_exec_shifted) begin
                check_eq("sb_nonempty", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    logic [52:0] e;
                    e = sb.pop_front();
                    check_eq("xbar_sel", 64'(o__xbar_sel), 64'(e[48:0]));
                    check_eq("regbypass", 64'(o__regbypass), 64'(e[52:49]));
                end
            end else begin
                check_eq("idle_outputs", 64'({o__xbar_sel, o__regbypass}), 64'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk_g_0);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic write_cfg(input logic [3:0] addr, input logic [52:0] data);
        i__cfg_we   = 1'b1;
        i__cfg_addr = addr;
        i__cfg_data = data;
        tick();
        i__cfg_we   = 1'b0;
        tb_mem[addr] = data;
    endtask

    // Queues n_words expected words, then issues start; returns 1ns after edge T.
    task automatic start_run(input logic [4:0] ii, input logic [15:0] it, input int n_words);
        int ii_r;
        ii_r = (ii > 5'd16) ? 16 : int'(ii);
        for (int k = 0; k < n_words; k++) sb.push_back(model_out(tb_mem[k % ii_r]));
        i__ii         = ii;
        i__iter_count = it;
        i__start      = 1'b1;
        tick();
        i__start      = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        int lat;
        lat = 200;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk_g_0);
            if (o__done) begin
                lat = k;
                break;
            end
        end
        check_eq({tag, "_done_lat"}, 64'(lat), 64'(exp_lat));
        @(negedge clk_g_0);
        check_eq({tag, "_done_pulse"}, 64'(o__done), 64'd0);
        check_eq({tag, "_busy_after"}, 64'(o__busy), 64'd0);
        check_eq({tag, "_sx_after"}, 64'(o__start_exec_shifted), 64'd0);
        check_eq({tag, "_xbar_after"}, 64'(o__xbar_sel), 64'd0);
        check_eq({tag, "_sb_drained"}, 64'(sb.size()), 64'd0);
        sb.delete();
        #1;
    endtask

    initial begin
        reset = 1'b1; i__cfg_we = 1'b0; i__cfg_addr = '0; i__cfg_data = '0;
        i__ii = '0; i__iter_count = '0; i__start = 1'b0; i__stop = 1'b0;
        repeat (3) @(posedge clk_g_0);
        #1;
        reset = 1'b0;
        @(negedge clk_g_0);
        check_eq("rst_busy", 64'(o__busy), 64'd0);
        check_eq("rst_xbar", 64'(o__xbar_sel), 64'd0);
        check_eq("rst_regbyp", 64'(o__regbypass), 64'd0);
        check_eq("rst_sx", 64'(o__start_exec_shifted), 64'd0);
        check_eq("rst_done", 64'(o__done), 64'd0);
        check_eq("rst_err", 64'(o__err), 64'd0);
        check_eq("rst_ctx", 64'(o__ctx), 64'd0);
        mon_en = 1'b1;
        tick();

        // Basic replay: ii=2, iter=3.
        write_cfg(4'd0, 53'd1);
        write_cfg(4'd1, {4'b0101, 49'd0} | (53'h10 << 14));
        start_run(5'd2, 16'd3, 6);
        wait_done("basic", 6);
        check_eq("basic_err", 64'(o__err), 64'd0);

        // ii=1, free-running until stop sampled six edges after start.
        start_run(5'd1, 16'd0, 6);
        fork
            wait_done("stop", 6);
            begin
                repeat (5) @(posedge clk_g_0);
                #1 i__stop = 1'b1;
                @(posedge clk_g_0);
                #1 i__stop = 1'b0;
            end
        join
        check_eq("stop_err", 64'(o__err), 64'd0);

        // Host write while running is dropped and flagged.
        start_run(5'd2, 16'd2, 4);
        fork
            wait_done("we_run", 4);
            begin
                @(posedge clk_g_0);
                #1;
                i__cfg_we = 1'b1; i__cfg_addr = 4'd0; i__cfg_data = {53{1'b1}};
                @(posedge clk_g_0);
                #1 i__cfg_we = 1'b0;
            end
        join
        check_eq("we_run_err", 64'(o__err), 64'd1);
        start_run(5'd1, 16'd1, 1);
        wait_done("we_keep", 1);
        do_reset();
        @(negedge clk_g_0);
        check_eq("reset_clears_err", 64'(o__err), 64'd0);
        tick();

        // ii clipped to the memory depth.
        for (int a = 2; a < 16; a++) begin
            logic [52:0] w;
            w = '0;
            for (int j = 0; j < 7; j++) begin
                int s;
                s = $urandom_range(0, 7);
                if (s < 7) w[j*7 + s] = 1'b1;
            end
            w[52:49] = 4'($urandom);
            write_cfg(4'(a), w);
        end
        start_run(5'd20, 16'd1, 16);
        wait_done("ii_clip", 16);
        check_eq("ii_clip_err", 64'(o__err), 64'd0);

        // ii=0 start is rejected.
        i__ii = 5'd0; i__iter_count = 16'd1; i__start = 1'b1;
        tick();
        i__start = 1'b0;
        @(negedge clk_g_0);
        check_eq("ii0_busy", 64'(o__busy), 64'd0);
        check_eq("ii0_err", 64'(o__err), 64'd1);
        tick();
        do_reset();

        // Multi-hot field on out3 is suppressed, others pass, err is sticky.
        write_cfg(4'd0, {4'b1010, 49'd0} | (53'h03 << 21) | (53'h40 << 7) | 53'd1);
        @(negedge clk_g_0);
        check_eq("mh_err_pre", 64'(o__err), 64'd0);
        #1;
        start_run(5'd1, 16'd2, 2);
        wait_done("mh", 2);
        check_eq("mh_err", 64'(o__err), 64'd1);
        repeat (3) tick();
        @(negedge clk_g_0);
        check_eq("mh_err_sticky", 64'(o__err), 64'd1);
        #1;
        do_reset();

        // Reset mid-run, then replay of retained contents.
        write_cfg(4'd0, 53'h2 << 28);
        start_run(5'd2, 16'd0, 2);
        @(posedge clk_g_0);
        @(posedge clk_g_0);
        #1 reset = 1'b1;
        @(posedge clk_g_0);
        #1 reset = 1'b0;
        @(negedge clk_g_0);
        check_eq("mid_rst_busy", 64'(o__busy), 64'd0);
        check_eq("mid_rst_xbar", 64'(o__xbar_sel), 64'd0);
        check_eq("mid_rst_sx", 64'(o__start_exec_shifted), 64'd0);
        check_eq("mid_rst_sb", 64'(sb.size()), 64'd0);
        sb.delete();
        #1;
        start_run(5'd2, 16'd2, 4);
        wait_done("restart", 4);
        check_eq("restart_err", 64'(o__err), 64'd0);

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
